// File: rtl/pdm_decimator.sv
// rtl/pdm_decimator.sv - 3rd-order CIC decimator turning a 1-bit PDM stream into 16-bit PCM
// Integrators run on accepted strobes; one comb pass per frame feeds a ready/valid output register.
module pdm_decimator #(
  parameter int DECIM = 64,
  parameter int W     = 3 * $clog2(DECIM) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        pdm_in,
  input  logic        pdm_strobe,
  output logic [15:0] pcm_out,
  output logic        pcm_valid,
  input  logic        pcm_ready,
  output logic        overrun,
  input  logic        clear_overrun
);

  localparam int            PW         = $clog2(DECIM);
  localparam logic [PW-1:0] LAST_PHASE = PW'(DECIM - 1);

  logic [W-1:0]  i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  logic [W-1:0]  d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic [W-1:0]  c1, c2, c3;
  logic [PW-1:0] phase_q, phase_d;
  logic          frame_end_q, frame_end_d;
  logic [16:0]   y_sh;
  logic [15:0]   sample;
  logic [15:0]   pcm_q, pcm_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;
  logic          accept;

  assign accept = pdm_strobe & enable;

  always_comb begin
    i1_d        = i1_q;
    i2_d        = i2_q;
    i3_d        = i3_q;
    phase_d     = phase_q;
    frame_end_d = 1'b0;
    if (accept) begin
      // Pipelined cascade: each stage adds the pre-edge value of the one before it.
      i1_d        = i1_q + W'(pdm_in);
      i2_d        = i2_q + i1_q;
      i3_d        = i3_q + i2_q;
      frame_end_d = (phase_q == LAST_PHASE);
      phase_d     = frame_end_d ? '0 : phase_q + PW'(1);
    end
  end

  always_comb begin
    c1   = i3_q - d1_q;
    c2   = c1 - d2_q;
    c3   = c2 - d3_q;
    d1_d = d1_q;
    d2_d = d2_q;
    d3_d = d3_q;
    if (frame_end_q) begin
      d1_d = i3_q;
      d2_d = c1;
      d3_d = c2;
    end
    // Full scale DECIM^3 maps to 65536; flipping the MSB subtracts the 32768 offset.
    y_sh   = 17'(c3 >> (W - 17));
    sample = y_sh[16] ? 16'h7FFF : {~y_sh[15], y_sh[14:0]};
  end

  always_comb begin
    pcm_d   = pcm_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (valid_q && pcm_ready) valid_d = 1'b0;
    if (clear_overrun)        ovr_d   = 1'b0;
    if (frame_end_q) begin
      pcm_d   = sample;
      valid_d = 1'b1;
      if (valid_q && !pcm_ready) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i1_q        <= '0;
      i2_q        <= '0;
      i3_q        <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
      d3_q        <= '0;
      phase_q     <= '0;
      frame_end_q <= 1'b0;
      pcm_q       <= '0;
      valid_q     <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      i1_q        <= i1_d;
      i2_q        <= i2_d;
      i3_q        <= i3_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      d3_q        <= d3_d;
      phase_q     <= phase_d;
      frame_end_q <= frame_end_d;
      pcm_q       <= pcm_d;
      valid_q     <= valid_d;
      ovr_q       <= ovr_d;
    end
  end

  assign pcm_out   = pcm_q;
  assign pcm_valid = valid_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_pdm_decimator.sv
// tb/tb_pdm_decimator.sv - directed scoreboard bench for pdm_decimator (DECIM=64)
module tb_pdm_decimator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        pdm_in = 1'b0;
  logic        pdm_strobe = 1'b0;
  logic [15:0] pcm_out;
  logic        pcm_valid;
  logic        pcm_ready = 1'b1;
  logic        overrun;
  logic        clear_overrun = 1'b0;

  pdm_decimator dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .pdm_in        (pdm_in),
    .pdm_strobe    (pdm_strobe),
    .pcm_out       (pcm_out),
    .pcm_valid     (pcm_valid),
    .pcm_ready     (pcm_ready),
    .overrun       (overrun),
    .clear_overrun (clear_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] val;
    bit          chk;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   phase_m = 0;
  int   frame_m = 0;
  int   mode = 0;
  logic prev_valid = 1'b0;
  logic b;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Closed-form results: with all-ones input from reset, i3 after N strobes is C(N,3).
  function automatic exp_t make_exp(input int due, input int md, input int idx);
    exp_t e;
    e.due = due;
    e.chk = 1'b1;
    case (md)
      0:       e.val = (idx == 1) ? 16'hA8B0 : (idx == 2) ? 16'h5350 : 16'h7FFF;
      1:       e.val = 16'h8000;
      default: begin e.val = 16'h0000; e.chk = (idx >= 4); end
    endcase
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      check("valid_at_due", 16'(pcm_valid), 16'd1);
      if (sb[0].chk) check("pcm_value", pcm_out, sb[0].val);
      void'(sb.pop_front());
    end else begin
      check("no_spurious_rise", 16'(pcm_valid & ~prev_valid), 16'd0);
    end
    prev_valid = pcm_valid;
  endtask

  task automatic drive(input logic s, input logic x);
    pdm_strobe = s;
    pdm_in     = x;
    if (rst) begin
      sb.delete();
      phase_m = 0;
      frame_m = 0;
    end else if (s && enable) begin
      if (phase_m == 63) begin
        frame_m++;
        sb.push_back(make_exp(cyc + 2, mode, frame_m));
        phase_m = 0;
      end else begin
        phase_m++;
      end
    end
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b1, 1'b1);
    rst = 1'b0;
  endtask

  initial begin
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b1);
    rst = 1'b0;
    check("reset_pcm_out", pcm_out, 16'h0000);
    check("reset_pcm_valid", 16'(pcm_valid), 16'd0);
    check("reset_overrun", 16'(overrun), 16'd0);

    // all ones, strobe every 4 cycles
    mode = 0;
    repeat (5 * 64) begin drive(1'b1, 1'b1); repeat (3) drive(1'b0, 1'b1); end
    repeat (4) drive(1'b0, 1'b1);
    check("ones_overrun", 16'(overrun), 16'd0);

    // all zeros
    mode = 1;
    do_reset();
    repeat (5 * 64) begin drive(1'b1, 1'b0); repeat (3) drive(1'b0, 1'b0); end
    repeat (4) drive(1'b0, 1'b0);

    // alternating 1,0,...
    mode = 2;
    do_reset();
    b = 1'b1;
    repeat (5 * 64) begin drive(1'b1, b); b = ~b; repeat (3) drive(1'b0, b); end
    repeat (4) drive(1'b0, 1'b0);

    // backpressure across two frame ends, consecutive strobes
    mode = 0;
    pcm_ready = 1'b0;
    do_reset();
    repeat (128) drive(1'b1, 1'b1);
    repeat (3) drive(1'b0, 1'b1);
    check("bp_valid_held", 16'(pcm_valid), 16'd1);
    check("bp_second_sample", pcm_out, 16'h5350);
    check("bp_overrun_set", 16'(overrun), 16'd1);
    clear_overrun = 1'b1;
    drive(1'b0, 1'b1);
    clear_overrun = 1'b0;
    check("bp_overrun_cleared", 16'(overrun), 16'd0);
    check("bp_valid_still_held", 16'(pcm_valid), 16'd1);
    // third frame loads in the same cycle as a handshake
    repeat (64) drive(1'b1, 1'b1);
    pcm_ready = 1'b1;
    drive(1'b0, 1'b1);
    check("hs_load_overrun", 16'(overrun), 16'd0);
    drive(1'b0, 1'b1);
    check("hs_valid_drops", 16'(pcm_valid), 16'd0);

    // reset in the middle of a frame, with overrun and valid pending
    pcm_ready = 1'b0;
    do_reset();
    repeat (128 + 30) drive(1'b1, 1'b1);
    check("mid_valid_before", 16'(pcm_valid), 16'd1);
    check("mid_overrun_before", 16'(overrun), 16'd1);
    do_reset();
    check("mid_rst_pcm_out", pcm_out, 16'h0000);
    check("mid_rst_valid", 16'(pcm_valid), 16'd0);
    check("mid_rst_overrun", 16'(overrun), 16'd0);
    pcm_ready = 1'b1;
    repeat (64) drive(1'b1, 1'b1);
    repeat (4) drive(1'b0, 1'b1);

    // enable gating mid-frame
    do_reset();
    repeat (20) drive(1'b1, 1'b1);
    enable = 1'b0;
    repeat (100) drive(1'b1, 1'b1);
    check("gate_no_valid", 16'(pcm_valid), 16'd0);
    enable = 1'b1;
    repeat (43) drive(1'b1, 1'b1);
    repeat (4) drive(1'b0, 1'b1);
    check("gate_frame_incomplete", 16'(pcm_valid), 16'd0);
    drive(1'b1, 1'b1);
    repeat (4) drive(1'b0, 1'b1);

    check("scoreboard_empty", 16'(sb.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
